// File: rtl/aud_pkg.sv
// rtl/aud_pkg.sv - shared types and widths for the audio capture path
// Purpose: recorder state encoding and default data/address widths.
// Ports: none (package).
package aud_pkg;

    localparam int AUD_DATA_W = 16;
    localparam int AUD_ADDR_W = 20;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_L,
        SKIP,
        SHIFT,
        WRITE,
        PAUSE
    } rec_state_t;

endpackage

// File: rtl/aud_sync_edge.sv
// rtl/aud_sync_edge.sv - two-flop synchroniser with rise/fall pulses
// Purpose: brings an asynchronous codec line into the i_clk domain and flags its edges.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous reset, active-high
//   din      asynchronous input
//   sync     synchronised level
//   rise     1-cycle pulse on synchronised 0->1
//   fall     1-cycle pulse on synchronised 1->0
module aud_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync_q;
    logic prev;

    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            meta   <= 1'b0;
            sync_q <= 1'b0;
            prev   <= 1'b0;
        end else begin
            meta   <= din;
            sync_q <= meta;
            prev   <= sync_q;
        end
    end

    assign sync = sync_q;
    assign rise = sync_q & ~prev;
    assign fall = ~sync_q & prev;

endmodule

// File: rtl/aud_recorder.sv
// rtl/aud_recorder.sv - I2S left-channel capture into SRAM
// Purpose: deserialises left-channel samples from the ADC and writes one per
//   LRCK frame to consecutive SRAM addresses; reports the last written address.
// Optional macro AUD_REC_PEAK_EN adds o_peak (max |sample| since start from IDLE).
// Ports:
//   i_clk, i_rst_n        system clock; asynchronous active-high reset
//   i_start/i_pause/i_stop 1-cycle control pulses (stop > pause > start)
//   i_bclk, i_lrck, i_adcdat  asynchronous codec I2S lines
//   o_sram_addr/o_sram_data/o_sram_we  SRAM write port
//   o_busy                not IDLE
//   o_full                sticky, set when ADDR_MAX is written
//   o_end_addr            address of the last sample written
//   o_peak                (AUD_REC_PEAK_EN only) peak magnitude
module aud_recorder
    import aud_pkg::*;
#(
    parameter int                 DATA_W   = AUD_DATA_W,
    parameter int                 ADDR_W   = AUD_ADDR_W,
    parameter logic [ADDR_W-1:0]  ADDR_MAX = {ADDR_W{1'b1}}
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_bclk,
    input  logic              i_lrck,
    input  logic              i_adcdat,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_data,
    output logic              o_sram_we,
    output logic              o_busy,
    output logic              o_full,
    output logic [ADDR_W-1:0] o_end_addr
`ifdef AUD_REC_PEAK_EN
    ,
    output logic [DATA_W-2:0] o_peak
`endif
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    rec_state_t state;
    rec_state_t state_nx;

    logic              bclk_sync;
    logic              bclk_rise;
    logic              bclk_fall;
    logic              lrck_sync;
    logic              lrck_rise;
    logic              frame_start;
    logic              adc_meta;
    logic              adc_sync;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr;
    logic              pause_pending;
    logic              unused_sig;

    aud_sync_edge u_bclk (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .din     (i_bclk),
        .sync    (bclk_sync),
        .rise    (bclk_rise),
        .fall    (bclk_fall)
    );

    aud_sync_edge u_lrck (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .din     (i_lrck),
        .sync    (lrck_sync),
        .rise    (lrck_rise),
        .fall    (frame_start)
    );

    assign unused_sig = ^{bclk_sync, bclk_fall, lrck_sync, lrck_rise};

    // Same two-stage depth as BCLK, so the data bit lines up with bclk_rise.
    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            adc_meta <= 1'b0;
            adc_sync <= 1'b0;
        end else begin
            adc_meta <= i_adcdat;
            adc_sync <= adc_meta;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        o_sram_we = 1'b0;
        if (i_stop) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:   if (i_start) state_nx = WAIT_L;
                WAIT_L: begin
                    if (i_pause)          state_nx = PAUSE;
                    else if (frame_start) state_nx = SKIP;
                end
                // First BCLK after the LRCK fall is the I2S delay slot.
                SKIP:   if (bclk_rise) state_nx = SHIFT;
                SHIFT: begin
                    if (frame_start)                         state_nx = SKIP;
                    else if (bclk_rise && (cnt == CNT_LAST)) state_nx = WRITE;
                end
                WRITE: begin
                    o_sram_we = 1'b1;
                    if (addr == ADDR_MAX)              state_nx = IDLE;
                    else if (pause_pending || i_pause) state_nx = PAUSE;
                    else                               state_nx = WAIT_L;
                end
                PAUSE:  if (i_start && !i_pause) state_nx = WAIT_L;
                default: state_nx = IDLE;
            endcase
        end
    end

`ifdef AUD_REC_PEAK_EN
    logic [DATA_W-1:0] neg;
    logic [DATA_W-2:0] mag;

    assign neg = ~shreg + DATA_W'(1);

    // The most negative code has no positive twin; clamp it to all ones.
    always_comb begin
        mag = shreg[DATA_W-2:0];
        if (shreg[DATA_W-1]) begin
            if (shreg[DATA_W-2:0] == '0) mag = '1;
            else                         mag = neg[DATA_W-2:0];
        end
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            shreg         <= '0;
            cnt           <= '0;
            addr          <= '0;
            o_end_addr    <= '0;
            o_full        <= 1'b0;
            pause_pending <= 1'b0;
`ifdef AUD_REC_PEAK_EN
            o_peak        <= '0;
`endif
        end else if (i_stop) begin
            shreg         <= '0;
            cnt           <= '0;
            pause_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        addr          <= '0;
                        cnt           <= '0;
                        o_full        <= 1'b0;
                        pause_pending <= 1'b0;
`ifdef AUD_REC_PEAK_EN
                        o_peak        <= '0;
`endif
                    end
                end
                WAIT_L: cnt <= '0;
                SKIP: begin
                    cnt <= '0;
                    if (i_pause) pause_pending <= 1'b1;
                end
                SHIFT: begin
                    if (i_pause) pause_pending <= 1'b1;
                    if (frame_start) begin
                        shreg <= '0;
                        cnt   <= '0;
                    end else if (bclk_rise) begin
                        shreg <= {shreg[DATA_W-2:0], adc_sync};
                        cnt   <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    o_end_addr    <= addr;
                    pause_pending <= 1'b0;
                    if (addr == ADDR_MAX) o_full <= 1'b1;
                    else                  addr   <= addr + ADDR_W'(1);
`ifdef AUD_REC_PEAK_EN
                    if (mag > o_peak) o_peak <= mag;
`endif
                end
                default: ;
            endcase
        end
    end

    assign o_sram_addr = addr;
    assign o_sram_data = shreg;
    assign o_busy      = (state != IDLE);

endmodule
